// File: rtl/psum_accumulator.sv
// Accumulates per-column partial sums across input-channel passes and queues
// finished results in a show-ahead FIFO, back-pressuring the PE FSM when full.
module psum_accumulator #(
  parameter int T      = 14,
  parameter int PSUM_W = 24,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_conv,
  input  logic              p_valid,
  input  logic              last_chanel,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              end_conv,
  output logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              done
);

  localparam int COL_W = (T > 1) ? $clog2(T) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(T - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);

  logic [COL_W-1:0] r_col;
  logic             r_firstPass;
  logic             r_endSeen;
  logic [ACC_W-1:0] r_acc [T];
  logic [ACC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_cnt;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [COL_W-1:0] w_colEff;
  logic             w_firstEff;
  logic [ACC_W-1:0] w_sext;
  logic [ACC_W-1:0] w_sum;

  // start_conv takes effect on a beat accepted in the same cycle
  assign w_colEff   = start_conv ? '0 : r_col;
  assign w_firstEff = start_conv | r_firstPass;

  assign w_accept = p_valid & ~stall;
  assign w_push   = w_accept & last_chanel;
  assign w_pop    = out_valid & out_ready;

  assign w_sext = ACC_W'($signed(psum_in));
  assign w_sum  = w_firstEff ? w_sext : r_acc[w_colEff] + w_sext;

  assign stall     = (r_cnt == FULL_CNT);
  assign out_valid = (r_cnt != '0);
  assign out_data  = out_valid ? r_mem[r_rdPtr] : '0;
  assign done      = r_endSeen & (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_firstPass <= 1'b1;
      r_endSeen   <= 1'b0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_accept) begin
        if (w_colEff == LAST_COL) begin
          r_col       <= '0;
          r_firstPass <= last_chanel;
        end else begin
          r_col       <= w_colEff + COL_W'(1);
          r_firstPass <= w_firstEff;
        end
      end else if (start_conv) begin
        r_col       <= '0;
        r_firstPass <= 1'b1;
      end

      if (start_conv || done) begin
        r_endSeen <= 1'b0;
      end else if (end_conv) begin
        r_endSeen <= 1'b1;
      end

      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage arrays need no reset: first_pass and cnt gate every read
  always_ff @(posedge clk) begin
    if (w_accept && !last_chanel) begin
      r_acc[w_colEff] <= w_sum;
    end
    if (w_push) begin
      r_mem[r_wrPtr] <= w_sum;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomised and directed bench for psum_accumulator, checked every cycle
// against a queue-based reference model of the accumulation rules.
module tb_psum_accumulator;

  localparam int T      = 14;
  localparam int PSUM_W = 24;
  localparam int ACC_W  = 32;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_conv;
  logic              p_valid;
  logic              last_chanel;
  logic [PSUM_W-1:0] psum_in;
  logic              end_conv;
  logic              stall;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              done;

  int nCompared   = 0;
  int nMismatched = 0;

  psum_accumulator #(.T(T), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_conv(start_conv), .p_valid(p_valid),
    .last_chanel(last_chanel), .psum_in(psum_in), .end_conv(end_conv),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays and a queue standing in for the FIFO
  logic [ACC_W-1:0] mAcc [T];
  logic [ACC_W-1:0] mQ [$];
  int               mCol;
  bit               mFirst;
  bit               mEnd;
  bit               modelReady = 1'b0;
  int               effCol;
  bit               effFirst;
  bit               wasFull;
  bit               doneNow;
  logic [ACC_W-1:0] sVal;
  logic [ACC_W-1:0] sumVal;

  always @(posedge clk) begin
    if (rst) begin
      mQ.delete();
      mCol       = 0;
      mFirst     = 1'b1;
      mEnd       = 1'b0;
      modelReady = 1'b1;
    end else if (modelReady) begin
      wasFull  = (mQ.size() == DEPTH);
      doneNow  = mEnd && (mQ.size() == 0);
      effCol   = start_conv ? 0 : mCol;
      effFirst = start_conv ? 1'b1 : mFirst;
      if (start_conv) begin
        mCol   = 0;
        mFirst = 1'b1;
      end
      if (mQ.size() > 0 && out_ready) void'(mQ.pop_front());
      if (p_valid && !wasFull) begin
        sVal   = ACC_W'(int'($signed(psum_in)));
        sumVal = effFirst ? sVal : mAcc[effCol] + sVal;
        if (last_chanel) mQ.push_back(sumVal);
        else mAcc[effCol] = sumVal;
        if (effCol == T - 1) begin
          mCol   = 0;
          mFirst = last_chanel;
        end else begin
          mCol   = effCol + 1;
          mFirst = effFirst;
        end
      end
      if (start_conv || doneNow) mEnd = 1'b0;
      else if (end_conv) mEnd = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("stall", 32'(stall), 32'(mQ.size() == DEPTH));
      checkOutput("out_valid", 32'(out_valid), 32'(mQ.size() != 0));
      checkOutput("out_data", out_data, (mQ.size() != 0) ? mQ[0] : 32'h0);
      checkOutput("done", 32'(done), 32'(mEnd && mQ.size() == 0));
    end
  end

  logic [ACC_W-1:0] popLog [$];
  int               doneCount = 0;
  int               doneAtPops = -1;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) popLog.push_back(out_data);
    if (!rst && done) begin
      doneCount++;
      doneAtPops = popLog.size();
    end
  end

  // Present one beat and hold it until the DUT accepts it
  task automatic applyStimulus(input logic [PSUM_W-1:0] value, input logic last);
    bit wasStalled;
    int waited;
    p_valid     = 1'b1;
    last_chanel = last;
    psum_in     = value;
    waited      = 0;
    forever begin
      wasStalled = stall;
      @(negedge clk);
      if (!wasStalled) break;
      waited++;
      if (waited > 200) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL beatTimeout: got stalled, expected accepted at %0t", $time);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    p_valid    = 1'b0;
    start_conv = 1'b0;
    end_conv   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [ACC_W-1:0] pushVals [$];
  logic [PSUM_W-1:0] rv;

  initial begin
    rst = 1'b1; start_conv = 1'b0; p_valid = 1'b0; last_chanel = 1'b0;
    psum_in = '0; end_conv = 1'b0; out_ready = 1'b0;

    // Reset with random inputs
    repeat (2) begin
      start_conv = 1'($urandom); p_valid = 1'($urandom); last_chanel = 1'($urandom);
      psum_in = PSUM_W'($urandom); end_conv = 1'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
    end
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    rst = 1'b0; last_chanel = 1'b0; out_ready = 1'b1;
    idle(1);

    // Three channel passes, twice
    repeat (2) begin
      popLog.delete();
      for (int c = 0; c < 3; c++)
        for (int j = 0; j < T; j++)
          applyStimulus(PSUM_W'(10 * c + j), c == 2);
      idle(3);
      checkOutput("three_pass_count", popLog.size(), 32'd14);
      for (int j = 0; j < T && j < popLog.size(); j++)
        checkOutput("three_pass_value", popLog[j], 32'(30 + 3 * j));
    end

    // Single channel, negative value
    popLog.delete();
    for (int j = 0; j < T; j++) applyStimulus(24'hFFFFFE, 1'b1);
    idle(3);
    checkOutput("neg_count", popLog.size(), 32'd14);
    if (popLog.size() > 0) checkOutput("neg_first", popLog[0], 32'hFFFFFFFE);
    if (popLog.size() > 13) checkOutput("neg_last", popLog[13], 32'hFFFFFFFE);

    // Fill the FIFO, hold a beat, then drain
    out_ready = 1'b0;
    popLog.delete();
    pushVals.delete();
    for (int k = 0; k < DEPTH; k++) begin
      rv = PSUM_W'($urandom);
      pushVals.push_back(ACC_W'(int'($signed(rv))));
      applyStimulus(rv, 1'b1);
    end
    p_valid = 1'b1; last_chanel = 1'b1; psum_in = 24'h000123;
    checkOutput("full_stall", 32'(stall), 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("full_stall_held", 32'(stall), 32'h1);
    out_ready = 1'b1;
    applyStimulus(24'h000123, 1'b1);
    idle(DEPTH + 8);
    checkOutput("drain_count", popLog.size(), 32'(DEPTH + 1));
    for (int k = 0; k < DEPTH && k < popLog.size(); k++)
      checkOutput("drain_order", popLog[k], pushVals[k]);
    if (popLog.size() > DEPTH) checkOutput("held_beat", popLog[DEPTH], 32'h00000123);

    // done after the fifth pop
    start_conv = 1'b1; @(negedge clk); start_conv = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(PSUM_W'(k + 1), 1'b1);
    p_valid = 1'b0;
    popLog.delete();
    doneCount  = 0;
    doneAtPops = -1;
    end_conv = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    end_conv = 1'b0;
    idle(10);
    checkOutput("done_pulses", doneCount, 32'd1);
    checkOutput("done_after_pops", doneAtPops, 32'd5);

    // start_conv mid-row discards partial accumulation
    for (int k = 0; k < 6; k++) applyStimulus(PSUM_W'($urandom), 1'b0);
    p_valid = 1'b0;
    start_conv = 1'b1; @(negedge clk); start_conv = 1'b0;
    popLog.delete();
    for (int j = 0; j < T; j++) applyStimulus(PSUM_W'(j), 1'b1);
    idle(4);
    checkOutput("restart_count", popLog.size(), 32'd14);
    for (int j = 0; j < T && j < popLog.size(); j++)
      checkOutput("restart_value", popLog[j], 32'(j));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      p_valid     = ($urandom_range(0, 99) < 70);
      last_chanel = ($urandom_range(0, 99) < 40);
      psum_in     = PSUM_W'($urandom);
      out_ready   = ($urandom_range(0, 99) < 60);
      start_conv  = ($urandom_range(0, 99) < 1);
      end_conv    = ($urandom_range(0, 99) < 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    idle(DEPTH + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
